// File: rtl/ram_arb_pkg.sv
// Shared types and address helpers for the two-port data RAM arbiter.
// Byte addresses become word indices by dropping the two low bits.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_A    = 2'd1,
      OWN_B    = 2'd2
   } owner_t;

   localparam int unsigned WORD_SHIFT = 2;

   function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
      return byte_addr >> WORD_SHIFT;
   endfunction

   function automatic logic word_in_range(input logic [31:0] byte_addr,
                                          input int unsigned depth);
      return word_index(byte_addr) < depth;
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester's access bundle: request/write/lock/address/data in, grant and
// one-cycle response (rvalid, err, rdata) back. The requester holds req until gnt.
interface ram_arbiter_if #(parameter int DATA_W = 32);

   logic              req;
   logic              we;
   logic              lock;
   logic [31:0]       addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic              err;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, lock, addr, wdata,
                   input  gnt, rvalid, err, rdata);

   modport slave  (input  req, we, lock, addr, wdata,
                   output gnt, rvalid, err, rdata);

endinterface

// File: rtl/ram_arb_port_resp.sv
// Per-port response register: rvalid/err pulse one cycle after issue; rdata is captured only on
// in-range reads and held otherwise. No backpressure, so the response is always accepted.
module ram_arb_port_resp #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue,
   input  logic              we,
   input  logic              in_range,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rvalid,
   output logic              err,
   output logic [DATA_W-1:0] rdata
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rvalid <= 1'b0;
         err    <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= issue;
         err    <= issue & ~in_range;
         if (issue && !we && in_range) begin
            rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter with bounded lock sharing a single-port RAM between ports A and B.
// Grant is combinational; the response follows one cycle later. Losers wait with req held.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 1024,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset,
   ram_arbiter_if.slave      port_a,
   ram_arbiter_if.slave      port_b,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   owner_t            owner_q, owner_d;
   logic              ptr_b_q, ptr_b_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              gnt_a, gnt_b, keep;
   logic              issue, in_range, sel_we;
   logic [31:0]       sel_addr, addr_q;
   logic [DATA_W-1:0] sel_wdata, wdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q <= OWN_NONE;
         ptr_b_q <= 1'b0;
         hold_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         owner_q <= owner_d;
         ptr_b_q <= ptr_b_d;
         hold_q  <= hold_d;
         if (issue) begin
            addr_q  <= word_index(sel_addr);
            wdata_q <= sel_wdata;
         end
      end
   end

   // The lock path either re-grants the owner or, once the hold budget is
   // spent and the other port waits, hands over; otherwise arbitrate openly.
   always_comb begin
      gnt_a   = 1'b0;
      gnt_b   = 1'b0;
      keep    = 1'b0;
      owner_d = OWN_NONE;
      ptr_b_d = ptr_b_q;
      hold_d  = '0;
      if (reset) begin
         unique case (owner_q)
            OWN_A: begin
               if (port_a.lock && port_a.req) begin
                  if (hold_q < HOLD_MAX || !port_b.req) begin
                     gnt_a = 1'b1;
                     keep  = 1'b1;
                  end else begin
                     gnt_b = 1'b1;
                  end
               end
            end
            OWN_B: begin
               if (port_b.lock && port_b.req) begin
                  if (hold_q < HOLD_MAX || !port_a.req) begin
                     gnt_b = 1'b1;
                     keep  = 1'b1;
                  end else begin
                     gnt_a = 1'b1;
                  end
               end
            end
            default: ;
         endcase

         if (!gnt_a && !gnt_b) begin
            if (port_a.req && port_b.req) begin
               gnt_a = !ptr_b_q;
               gnt_b = ptr_b_q;
            end else begin
               gnt_a = port_a.req;
               gnt_b = port_b.req;
            end
         end

         if (gnt_a) begin
            owner_d = OWN_A;
            ptr_b_d = 1'b1;
         end else if (gnt_b) begin
            owner_d = OWN_B;
            ptr_b_d = 1'b0;
         end

         if (gnt_a || gnt_b) begin
            if (!keep) begin
               hold_d = HOLD_W'(1);
            end else if (hold_q == HOLD_MAX) begin
               hold_d = hold_q;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
      end
   end

   // Without a grant the RAM-side address/data hold their last issued values.
   always_comb begin
      issue     = gnt_a | gnt_b;
      sel_addr  = gnt_b ? port_b.addr  : port_a.addr;
      sel_wdata = gnt_b ? port_b.wdata : port_a.wdata;
      sel_we    = gnt_b ? port_b.we    : port_a.we;
      in_range  = word_in_range(sel_addr, DEPTH);
      mem_addr  = issue ? word_index(sel_addr) : addr_q;
      mem_wdata = issue ? sel_wdata : wdata_q;
      mem_we    = issue & sel_we & in_range;
   end

   assign port_a.gnt = gnt_a;
   assign port_b.gnt = gnt_b;

   ram_arb_port_resp #(.DATA_W(DATA_W)) u_resp_a (
      .clk       (clk),
      .reset     (reset),
      .issue     (gnt_a),
      .we        (port_a.we),
      .in_range  (in_range),
      .mem_rdata (mem_rdata),
      .rvalid    (port_a.rvalid),
      .err       (port_a.err),
      .rdata     (port_a.rdata)
   );

   ram_arb_port_resp #(.DATA_W(DATA_W)) u_resp_b (
      .clk       (clk),
      .reset     (reset),
      .issue     (gnt_b),
      .we        (port_b.we),
      .in_range  (in_range),
      .mem_rdata (mem_rdata),
      .rvalid    (port_b.rvalid),
      .err       (port_b.err),
      .rdata     (port_b.rdata)
   );

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1024-word RAM.
module tb_ram_arbiter;

   logic        clk;
   logic        reset;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   logic [31:0] ram [0:1023];
   logic        ld_en;
   logic [9:0]  ld_idx;
   logic [31:0] ld_dat;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   ram_arbiter_if #(.DATA_W(32)) ia ();
   ram_arbiter_if #(.DATA_W(32)) ib ();

   ram_arbiter #(.DATA_W(32), .DEPTH(1024), .MAX_HOLD(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .port_a    (ia),
      .port_b    (ib),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = (mem_addr < 32'd1024) ? ram[mem_addr[9:0]] : 32'h0;

   always @(posedge clk) begin
      if (ld_en) ram[ld_idx] <= ld_dat;
      else if (mem_we && mem_addr < 32'd1024) ram[mem_addr[9:0]] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic set_a(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wdata);
      ia.req = req; ia.we = we; ia.lock = lock; ia.addr = addr; ia.wdata = wdata;
   endtask

   task automatic set_b(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wdata);
      ib.req = req; ib.we = we; ib.lock = lock; ib.addr = addr; ib.wdata = wdata;
   endtask

   task automatic load(input logic [9:0] idx, input logic [31:0] dat);
      ld_en = 1'b1; ld_idx = idx; ld_dat = dat;
      cyc();
      ld_en = 1'b0;
   endtask

   task automatic do_reset();
      set_a(0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0);
      reset = 1'b0;
      cyc();
      reset = 1'b1;
   endtask

   logic [6:0] lock_pat;

   initial begin
      reset = 1'b0;
      ld_en = 1'b0; ld_idx = '0; ld_dat = '0;
      set_a(0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0);
      #1;
      load(10'd0,    32'h1111_1111);
      load(10'd4,    32'hDEAD_BEEF);
      load(10'd1023, 32'h5A5A_5A5A);

      // Reset state, with a write request present that must be blocked.
      set_a(1, 1, 0, 32'h40, 32'hAAAA_5555);
      smp();
      chk("rst_a_rvalid", {31'd0, ia.rvalid}, 32'd0);
      chk("rst_a_err",    {31'd0, ia.err},    32'd0);
      chk("rst_a_rdata",  ia.rdata,           32'd0);
      chk("rst_b_rvalid", {31'd0, ib.rvalid}, 32'd0);
      chk("rst_b_rdata",  ib.rdata,           32'd0);
      chk("rst_a_gnt",    {31'd0, ia.gnt},    32'd0);
      chk("rst_mem_we",   {31'd0, mem_we},    32'd0);
      chk("rst_mem_addr", mem_addr,           32'd0);
      chk("rst_mem_wdat", mem_wdata,          32'd0);
      set_a(0, 0, 0, 0, 0);
      cyc();
      reset = 1'b1;

      // Single read from A of word 4.
      cyc();
      set_a(1, 0, 0, 32'h10, 0);
      smp();
      chk("t1_a_gnt",    {31'd0, ia.gnt}, 32'd1);
      chk("t1_b_gnt",    {31'd0, ib.gnt}, 32'd0);
      chk("t1_mem_addr", mem_addr,        32'd4);
      chk("t1_mem_we",   {31'd0, mem_we}, 32'd0);
      cyc();
      set_a(0, 0, 0, 0, 0);
      smp();
      chk("t1_a_rvalid", {31'd0, ia.rvalid}, 32'd1);
      chk("t1_a_rdata",  ia.rdata,           32'hDEAD_BEEF);
      chk("t1_a_err",    {31'd0, ia.err},    32'd0);
      chk("t1_hold_addr", mem_addr,          32'd4);
      cyc();
      smp();
      chk("t1_a_rv_pulse", {31'd0, ia.rvalid}, 32'd0);

      // Both request without lock: strict alternation from A.
      do_reset();
      set_a(1, 0, 0, 32'h0, 0);
      set_b(1, 0, 0, 32'h4, 0);
      for (int i = 0; i < 6; i++) begin
         smp();
         chk($sformatf("t2_a_gnt%0d", i), {31'd0, ia.gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("t2_b_gnt%0d", i), {31'd0, ib.gnt}, (i % 2 == 0) ? 32'd0 : 32'd1);
         cyc();
      end

      // A locks with B waiting: four A grants, one B, then A again.
      do_reset();
      set_a(1, 0, 1, 32'h0, 0);
      set_b(1, 0, 0, 32'h4, 0);
      lock_pat = 7'b1101111;
      for (int i = 0; i < 7; i++) begin
         smp();
         chk($sformatf("t3_a_gnt%0d", i), {31'd0, ia.gnt}, {31'd0, lock_pat[i]});
         chk($sformatf("t3_b_gnt%0d", i), {31'd0, ib.gnt}, {31'd0, ~lock_pat[i]});
         cyc();
      end
      set_a(0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0);
      cyc();

      // B writes word 8, A reads it back on the following cycle.
      set_b(1, 1, 0, 32'h20, 32'h1234_5678);
      smp();
      chk("t4_b_gnt",     {31'd0, ib.gnt}, 32'd1);
      chk("t4_mem_we",    {31'd0, mem_we}, 32'd1);
      chk("t4_mem_addr",  mem_addr,        32'd8);
      chk("t4_mem_wdata", mem_wdata,       32'h1234_5678);
      cyc();
      set_b(0, 0, 0, 0, 0);
      set_a(1, 0, 0, 32'h20, 0);
      smp();
      chk("t4_a_gnt",    {31'd0, ia.gnt},    32'd1);
      chk("t4_b_rvalid", {31'd0, ib.rvalid}, 32'd1);
      chk("t4_b_err",    {31'd0, ib.err},    32'd0);
      chk("t4_b_rdata",  ib.rdata,           32'd0);
      cyc();
      set_a(0, 0, 0, 0, 0);
      smp();
      chk("t4_a_rvalid", {31'd0, ia.rvalid}, 32'd1);
      chk("t4_a_rdata",  ia.rdata,           32'h1234_5678);

      // Out-of-range write to word 1024 never reaches the RAM.
      cyc();
      set_a(1, 1, 0, 32'h1000, 32'hCAFE_F00D);
      smp();
      chk("t5_a_gnt",    {31'd0, ia.gnt}, 32'd1);
      chk("t5_mem_we",   {31'd0, mem_we}, 32'd0);
      chk("t5_mem_addr", mem_addr,        32'd1024);
      cyc();
      set_a(0, 0, 0, 0, 0);
      smp();
      chk("t5_a_rvalid", {31'd0, ia.rvalid}, 32'd1);
      chk("t5_a_err",    {31'd0, ia.err},    32'd1);
      chk("t5_a_rdata",  ia.rdata,           32'h1234_5678);
      chk("t5_ram0",     ram[0],             32'h1111_1111);

      // Last legal word 1023 reads without error.
      cyc();
      set_a(1, 0, 0, 32'hFFC, 0);
      smp();
      chk("t5_top_addr", mem_addr, 32'd1023);
      cyc();
      set_a(0, 0, 0, 0, 0);
      smp();
      chk("t5_top_err",   {31'd0, ia.err}, 32'd0);
      chk("t5_top_rdata", ia.rdata,        32'h5A5A_5A5A);

      // Reset lands on a granted write.
      cyc();
      set_a(1, 1, 0, 32'h30, 32'hFFFF_0000);
      smp();
      chk("t6_pre_we", {31'd0, mem_we}, 32'd1);
      #1;
      reset = 1'b0;
      #1;
      chk("t6_mem_we",   {31'd0, mem_we},    32'd0);
      chk("t6_a_gnt",    {31'd0, ia.gnt},    32'd0);
      chk("t6_a_rdata",  ia.rdata,           32'd0);
      chk("t6_mem_addr", mem_addr,           32'd0);
      cyc();
      smp();
      chk("t6_a_rvalid", {31'd0, ia.rvalid}, 32'd0);
      chk("t6_a_err",    {31'd0, ia.err},    32'd0);
      chk("t6_ram12",    ram[12],            32'd0);
      set_a(1, 0, 0, 32'h0, 0);
      set_b(1, 0, 0, 32'h4, 0);
      cyc();
      reset = 1'b1;
      smp();
      chk("t6_ptr_a", {31'd0, ia.gnt}, 32'd1);
      chk("t6_ptr_b", {31'd0, ib.gnt}, 32'd0);
      cyc();
      set_a(0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
